// File: rtl/eq_pkg.sv
// Shared helpers for the equalizer band adder tree: width math and the
// saturate/wrap mapping from the exact tree result to the output width.
package eq_pkg;

  localparam int SAT_CNT_W = 16;
  localparam int MAX_W     = 128;

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic             ovf;
  } sat_res_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Extend a w-bit value held in the low bits of x to MAX_W bits.
  function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] x,
                                              input int w,
                                              input bit is_signed);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = (i < w) ? x[i] : (is_signed & x[w-1]);
    end
    return r;
  endfunction

  // x must already be extended to MAX_W. The caller keeps the low out_w bits.
  function automatic sat_res_t sat_extend(input logic [MAX_W-1:0] x,
                                          input int full_w,
                                          input int out_w,
                                          input bit is_signed,
                                          input bit do_sat);
    sat_res_t         r;
    logic [MAX_W-1:0] one;
    logic [MAX_W-1:0] hi;
    logic [MAX_W-1:0] lo;
    logic             fits;
    r.data = x;
    r.ovf  = 1'b0;
    one    = MAX_W'(1);
    hi     = is_signed ? (one << (out_w - 1)) - one : (one << out_w) - one;
    lo     = is_signed ? ~hi : '0;
    if (out_w < full_w) begin
      fits = 1'b1;
      for (int i = 0; i < MAX_W; i++) begin
        if (i >= out_w && x[i] != (is_signed ? x[out_w-1] : 1'b0)) fits = 1'b0;
      end
      if (!fits) begin
        r.ovf = 1'b1;
        if (do_sat) r.data = (is_signed && x[MAX_W-1]) ? lo : hi;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/eq_adder_level.sv
// One registered level of the band adder tree: PAIRS adjacent-pair sums,
// each one bit wider than its inputs, plus the level's valid bit.
module eq_adder_level
  import eq_pkg::*;
#(
  parameter int PAIRS  = 8,
  parameter int IN_W   = 17,
  parameter int SIGNED = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [2*PAIRS*IN_W-1:0]   in_data,
  input  logic                      in_valid,
  output logic [PAIRS*(IN_W+1)-1:0] out_data,
  output logic                      out_valid
);

  localparam int OW = IN_W + 1;

  logic [PAIRS*OW-1:0] data_d;
  logic [PAIRS*OW-1:0] data_q;
  logic                valid_q;

  function automatic logic [OW-1:0] ext1(input logic [IN_W-1:0] a);
    return {(SIGNED != 0) & a[IN_W-1], a};
  endfunction

  always_comb begin
    data_d = '0;
    for (int p = 0; p < PAIRS; p++) begin
      data_d[p*OW +: OW] = ext1(in_data[2*p*IN_W +: IN_W])
                         + ext1(in_data[(2*p+1)*IN_W +: IN_W]);
    end
  end

  // Data only moves with a valid beat; clr kills the valid bit alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid & ~clr;
      if (in_valid) data_q <= data_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/eq_adder_tree.sv
// Pipelined band adder tree: LOG2N pairwise adder levels followed by a
// registered saturate/wrap output stage and an overflow event counter.
module eq_adder_tree
  import eq_pkg::*;
#(
  parameter int N_TAPS   = 16,
  parameter int IN_W     = 17,
  parameter int OUT_W    = 20,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_TAPS*IN_W-1:0] taps,
  input  logic                   taps_valid,
  input  logic                   clr,
  output logic [OUT_W-1:0]       sum,
  output logic                   sum_valid,
  output logic                   sat_flag,
  output logic [SAT_CNT_W-1:0]   sat_count
);

  localparam int LOG2N  = clog2(N_TAPS);
  localparam int FULL_W = IN_W + LOG2N;

  for (genvar k = 0; k < LOG2N; k++) begin : g_lvl
    localparam int PAIRS = N_TAPS >> (k + 1);
    localparam int LW    = IN_W + k;

    logic [2*PAIRS*LW-1:0]   lvl_in;
    logic                    lvl_in_v;
    logic [PAIRS*(LW+1)-1:0] lvl_out;
    logic                    lvl_out_v;

    if (k == 0) begin : g_first
      assign lvl_in   = taps;
      assign lvl_in_v = taps_valid;
    end else begin : g_next
      assign lvl_in   = g_lvl[k-1].lvl_out;
      assign lvl_in_v = g_lvl[k-1].lvl_out_v;
    end

    eq_adder_level #(
      .PAIRS (PAIRS),
      .IN_W  (LW),
      .SIGNED(SIGNED)
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .in_data  (lvl_in),
      .in_valid (lvl_in_v),
      .out_data (lvl_out),
      .out_valid(lvl_out_v)
    );
  end

  logic [FULL_W-1:0]          tree_sum;
  logic                       tree_v;
  sat_res_t                   res;
  logic [MAX_W-OUT_W-1:0]     unused_res_hi;
  logic                       load;

  logic [OUT_W-1:0]           sum_d;
  logic [OUT_W-1:0]           sum_q;
  logic                       sum_valid_d;
  logic                       sum_valid_q;
  logic                       sat_flag_d;
  logic                       sat_flag_q;
  logic [SAT_CNT_W-1:0]       sat_count_d;
  logic [SAT_CNT_W-1:0]       sat_count_q;

  assign tree_sum = g_lvl[LOG2N-1].lvl_out;
  assign tree_v   = g_lvl[LOG2N-1].lvl_out_v;

  always_comb begin
    res = sat_extend(extend(MAX_W'(tree_sum), FULL_W, SIGNED != 0),
                     FULL_W, OUT_W, SIGNED != 0, SATURATE != 0);
  end

  assign unused_res_hi = res.data[MAX_W-1:OUT_W];

  // A clr on the edge an overflowing sample lands still leaves the counter at 0.
  always_comb begin
    load        = tree_v & ~clr;
    sum_d       = load ? res.data[OUT_W-1:0] : sum_q;
    sum_valid_d = load;
    sat_flag_d  = load & res.ovf;
    sat_count_d = sat_count_q;
    if (clr) begin
      sat_count_d = '0;
    end else if (sat_flag_d && sat_count_q != '1) begin
      sat_count_d = sat_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      sat_flag_q  <= sat_flag_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign sat_flag  = sat_flag_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_eq_adder_tree.sv
// Bench for eq_adder_tree: three configurations checked against an
// arithmetic reference model of the band sum and its latency.
module tb_eq_adder_tree;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  localparam int NT[3] = '{16, 16, 4};
  localparam int IW[3] = '{17, 17, 8};
  localparam int OW[3] = '{20, 20, 12};
  localparam int SG[3] = '{1, 1, 0};
  localparam int ST[3] = '{1, 0, 1};
  localparam int LG[3] = '{4, 4, 2};

  int   tv[3][16];
  logic tvalid[3];

  logic [16*17-1:0] taps_a, taps_w;
  logic [4*8-1:0]   taps_u;
  logic [19:0]      sum_a, sum_w;
  logic [11:0]      sum_u;
  logic             v_a, v_w, v_u, f_a, f_w, f_u;
  logic [15:0]      c_a, c_w, c_u;

  always_comb begin
    taps_a = '0;
    taps_w = '0;
    taps_u = '0;
    for (int i = 0; i < 16; i++) begin
      taps_a[i*17 +: 17] = tv[0][i][16:0];
      taps_w[i*17 +: 17] = tv[1][i][16:0];
    end
    for (int i = 0; i < 4; i++) taps_u[i*8 +: 8] = tv[2][i][7:0];
  end

  eq_adder_tree dut_a (
    .clk(clk), .rst(rst), .taps(taps_a), .taps_valid(tvalid[0]), .clr(clr),
    .sum(sum_a), .sum_valid(v_a), .sat_flag(f_a), .sat_count(c_a));

  eq_adder_tree #(.SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .taps(taps_w), .taps_valid(tvalid[1]), .clr(clr),
    .sum(sum_w), .sum_valid(v_w), .sat_flag(f_w), .sat_count(c_w));

  eq_adder_tree #(.N_TAPS(4), .IN_W(8), .OUT_W(12), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .taps(taps_u), .taps_valid(tvalid[2]), .clr(clr),
    .sum(sum_u), .sum_valid(v_u), .sat_flag(f_u), .sat_count(c_u));

  longint obs_sum[3];
  longint obs_v[3];
  longint obs_f[3];
  longint obs_c[3];

  always_comb begin
    obs_sum[0] = longint'($signed(sum_a));
    obs_sum[1] = longint'($signed(sum_w));
    obs_sum[2] = longint'(sum_u);
    obs_v[0] = longint'(v_a);  obs_v[1] = longint'(v_w);  obs_v[2] = longint'(v_u);
    obs_f[0] = longint'(f_a);  obs_f[1] = longint'(f_w);  obs_f[2] = longint'(f_u);
    obs_c[0] = longint'(c_a);  obs_c[1] = longint'(c_w);  obs_c[2] = longint'(c_u);
  end

  typedef struct {
    longint s;
    bit     f;
    int     due;
  } beat_t;

  beat_t  q[3][$];
  longint last[3];
  int     cnt[3];
  int     edge_no = 0;
  int     checks  = 0;
  int     errors  = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Exact band sum, then clamp or wrap into the output width.
  function automatic beat_t model(input int d);
    beat_t  b;
    longint s, hi, lo, w;
    int     fw;
    s = 0;
    for (int i = 0; i < NT[d]; i++) s += longint'(tv[d][i]);
    fw    = IW[d] + LG[d];
    b.s   = s;
    b.f   = 1'b0;
    b.due = 0;
    if (OW[d] < fw) begin
      hi = (SG[d] != 0) ? (longint'(1) << (OW[d] - 1)) - 1 : (longint'(1) << OW[d]) - 1;
      lo = (SG[d] != 0) ? -(longint'(1) << (OW[d] - 1)) : 0;
      if (s > hi || s < lo) begin
        b.f = 1'b1;
        if (ST[d] != 0) begin
          b.s = (s > hi) ? hi : lo;
        end else begin
          w = s & ((longint'(1) << OW[d]) - 1);
          if (SG[d] != 0 && w > hi) w -= longint'(1) << OW[d];
          b.s = w;
        end
      end
    end
    return b;
  endfunction

  task automatic flush_model();
    for (int d = 0; d < 3; d++) begin
      q[d].delete();
      last[d] = 0;
      cnt[d]  = 0;
    end
  endtask

  beat_t mb[3];
  bit    mcv[3];
  bit    mclr, mrst, mexp;
  beat_t mpop;

  always @(posedge clk) begin
    mclr = clr;
    mrst = rst;
    for (int d = 0; d < 3; d++) begin
      mcv[d]    = tvalid[d] && !mclr && !mrst;
      mb[d]     = model(d);
      mb[d].due = edge_no + LG[d];
    end
    #1;
    if (!mrst && !rst) begin
      for (int d = 0; d < 3; d++) begin
        if (mclr) begin
          q[d].delete();
          cnt[d] = 0;
        end
        mexp = (q[d].size() > 0) && (q[d][0].due == edge_no);
        check($sformatf("valid%0d@%0d", d, edge_no), obs_v[d], longint'(mexp));
        if (mexp) begin
          mpop    = q[d].pop_front();
          last[d] = mpop.s;
          if (mpop.f && cnt[d] < 65535) cnt[d]++;
          check($sformatf("flag%0d@%0d", d, edge_no), obs_f[d], longint'(mpop.f));
        end
        check($sformatf("sum%0d@%0d", d, edge_no), obs_sum[d], last[d]);
        check($sformatf("count%0d@%0d", d, edge_no), obs_c[d], longint'(cnt[d]));
        if (mcv[d]) q[d].push_back(mb[d]);
      end
    end
    edge_no++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_all(input int d, input int v);
    for (int i = 0; i < NT[d]; i++) tv[d][i] = v;
  endtask

  task automatic idle(input int n);
    for (int d = 0; d < 3; d++) tvalid[d] = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      tvalid[d] = 1'b0;
      set_all(d, 0);
    end
    flush_model();

    #1 rst = 1'b1;
    #1;
    check("rst_sum_a", obs_sum[0], 0);
    check("rst_valid_a", obs_v[0], 0);
    check("rst_flag_a", obs_f[0], 0);
    check("rst_count_a", obs_c[0], 0);
    check("rst_sum_u", obs_sum[2], 0);
    step();
    step();
    rst = 1'b0;
    idle(2);

    // all ones: 16, five edges after capture
    step();
    set_all(0, 1);
    tvalid[0] = 1'b1;
    step();
    idle(8);
    check("ones_sum", obs_sum[0], 16);

    // positive clamp and wrap, then negative clamp
    set_all(0, 65535);
    set_all(1, 65535);
    tvalid[0] = 1'b1;
    tvalid[1] = 1'b1;
    step();
    set_all(0, -65536);
    tvalid[1] = 1'b0;
    step();
    idle(8);
    check("neg_clamp_sum", obs_sum[0], -524288);
    check("clamp_count", obs_c[0], 2);
    check("wrap_sum", obs_sum[1], -16);
    check("wrap_count", obs_c[1], 1);

    // back-to-back beats 0..31
    set_all(0, 0);
    for (int n = 0; n < 32; n++) begin
      tv[0][0]  = n;
      tvalid[0] = 1'b1;
      step();
    end
    idle(8);
    check("b2b_last", obs_sum[0], 31);

    // random traffic with occasional clr
    for (int c = 0; c < 60; c++) begin
      for (int d = 0; d < 3; d++) tvalid[d] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 1) != 0) begin
          tv[0][i] = int'($urandom_range(0, 131071)) - 65536;
          tv[1][i] = int'($urandom_range(0, 131071)) - 65536;
        end else begin
          tv[0][i] = int'($urandom_range(0, 8191)) - 4096;
          tv[1][i] = int'($urandom_range(0, 8191)) - 4096;
        end
      end
      for (int i = 0; i < 4; i++) tv[2][i] = int'($urandom_range(0, 255));
      clr = ($urandom_range(0, 15) == 0);
      step();
    end
    clr = 1'b0;
    idle(8);

    // overflowing sample and clr on the same edge
    set_all(0, 65535);
    tvalid[0] = 1'b1;
    step();
    tvalid[0] = 1'b0;
    repeat (3) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    idle(4);
    check("clr_ovf_count", obs_c[0], 0);

    // clr at beat 2 of 0..3; only beat 3 emerges
    set_all(0, 65535);
    tvalid[0] = 1'b1;
    step();
    idle(8);
    for (int k = 0; k < 4; k++) begin
      set_all(0, k + 1);
      tvalid[0] = 1'b1;
      clr = (k == 2);
      step();
    end
    clr = 1'b0;
    idle(8);
    check("clr_beat3_sum", obs_sum[0], 64);
    check("clr_beat3_count", obs_c[0], 0);

    // async rst mid-flight
    set_all(0, 65535);
    tvalid[0] = 1'b1;
    step();
    idle(8);
    set_all(0, 2000);
    tvalid[0] = 1'b1;
    step();
    step();
    #3 rst = 1'b1;
    #1;
    check("arst_sum", obs_sum[0], 0);
    check("arst_valid", obs_v[0], 0);
    check("arst_flag", obs_f[0], 0);
    check("arst_count", obs_c[0], 0);
    flush_model();
    step();
    rst = 1'b0;
    idle(10);

    // small unsigned configuration
    set_all(2, 255);
    tvalid[2] = 1'b1;
    step();
    idle(6);
    check("u_sum", obs_sum[2], 1020);
    check("u_count", obs_c[2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eq_adder_tree.md
# eq_adder_tree

Parametrised, pipelined adder tree that sums the per-tap products of one equalizer band filter into a single band sample. It replaces the fixed 16-input, single-cycle band adders with one reusable block: configurable tap count and widths, signed arithmetic, a valid pipeline with fixed latency, and output saturation with an event counter. It sits between the band coefficient multipliers and the band mixer in the equalizer Wishbone peripheral, one instance per band.

## Interface
- N_TAPS, 16, number of tap inputs; power of two, 2..64
- IN_W, 17, width of each tap product
- OUT_W, 20, width of `sum`
- SIGNED, 1, 1 = two's-complement taps, 0 = unsigned
- SATURATE, 1, 1 = clamp on overflow of OUT_W, 0 = keep low OUT_W bits (wrap)
- Derived: LOG2N = clog2(N_TAPS); FULL_W = IN_W + LOG2N

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- taps  in  N_TAPS*IN_W  packed tap products, tap i at [i*IN_W +: IN_W]
- taps_valid  in  1  taps carry a new sample this cycle
- clr  in  1  synchronous flush: drops in-flight samples, clears sat_count
- sum  out  OUT_W  band sum
- sum_valid  out  1  one-cycle strobe, sum is new
- sat_flag  out  1  qualifies sum_valid: this sample was clamped/wrapped
- sat_count  out  16  number of overflowed samples since reset/clr, sticks at 0xFFFF

## Operation
- No backpressure; a new beat may be presented every cycle. Beats are never merged or dropped except by clr/rst.
- Tree: LOG2N registered levels; level k adds adjacent pairs of level k-1, growing width by 1 bit (sign-extend if SIGNED, zero-extend otherwise). Arithmetic is exact up to FULL_W.
- Output stage (registered) maps FULL_W result to OUT_W:
  - OUT_W >= FULL_W: extend, sat_flag = 0 always.
  - OUT_W < FULL_W, SATURATE=1: clamp to OUT_W max/min (signed: 2^(OUT_W-1)-1 / -2^(OUT_W-1); unsigned: 2^OUT_W-1), sat_flag = 1 when clamped.
  - OUT_W < FULL_W, SATURATE=0: low OUT_W bits, sat_flag = 1 when the discarded bits are not a pure sign/zero extension.
- sat_count increments on each sum_valid with sat_flag; saturates at 0xFFFF.
- sum holds its last value when sum_valid is low (no zeroing between samples).
- clr: valid bits of all levels and output cleared on the next edge; data registers need not clear; sat_count = 0. A beat presented with clr high is dropped. clr and an overflowing output on the same edge: counter ends at 0.
- rst (any time, including mid-flight): all valid bits 0, sum 0, sat_flag 0, sat_count 0; data registers 0.

## Timing
- Reset values: sum = 0, sum_valid = 0, sat_flag = 0, sat_count = 0.
- Latency LOG2N+1 edges: beat captured at edge t produces sum_valid high for the cycle following edge t+LOG2N (5 edges for N_TAPS=16).
- Throughput 1 sample/cycle; valid pattern at output equals input pattern delayed by LOG2N+1.
- Critical path: one IN_W+LOG2N adder, or comparator in output stage.

## Structure
- Shared package eq_pkg: clog2 function, saturate/extend function parametrised by widths and signedness, sat_count width constant (16).
- Sub-module eq_adder_level: one registered level of pairwise adders with its valid bit (parameters: pair count, input width, SIGNED), instantiated LOG2N times via generate.
- Output stage and counter stay in eq_adder_tree.

## Test plan
- Defaults, all taps = 1, one beat -> sum = 16, sat_flag = 0, sum_valid exactly one cycle, 5 edges after capture.
- All taps = 65535 -> exact 1048560 exceeds 20-bit signed; sum = 524287, sat_flag = 1, sat_count = 1; all taps = -65536 -> sum = -524288, sat_count = 2.
- SATURATE=0, all taps = 65535 -> sum = 1048560 mod 2^20 as signed = -16, sat_flag = 1.
- Back-to-back beats, tap0 = n, others 0, n = 0..31 every cycle -> sum = 0..31 on 32 consecutive sum_valid cycles, none lost.
- Beats in flight at cycles 0..3, rst pulse asynchronously mid-cycle 2 -> all outputs 0 immediately, no sum_valid afterwards; clr at cycle 2 instead -> no sum_valid from beats 0..2, beat 3 emerges normally, sat_count = 0.
- N_TAPS=4, IN_W=8, OUT_W=12, SIGNED=0: all taps = 255 -> sum = 1020, latency 3 edges, sat_flag = 0.
